// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receive front end: synchronises the pin, majority-samples each bit
// at mid-bit and presents complete bytes on a valid/ready holding register.
module uart_rx_deserializer #(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int CYCLE = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF  = CYCLE / 2;
    localparam int CW    = $clog2(CYCLE);

    localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
    localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    samp_q, samp_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_bad_q, frame_bad_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    logic rx_s;
    logic maj;
    logic at_last;
    logic at_dec;

    assign rx_s    = sync2_q;
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign at_last = (cycle_cnt_q == CNT_LAST);
    assign at_dec  = (cycle_cnt_q == CNT_DEC);

    // Synchroniser and edge-detect flops reset to 1 so a released reset never
    // looks like a start bit on an idle line.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= IDLE;
            cycle_cnt_q <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            samp_q      <= '0;
            frame_ok_q  <= 1'b0;
            frame_bad_q <= 1'b0;
            rx_data_q   <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= uart_rx;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            samp_q      <= samp_d;
            frame_ok_q  <= frame_ok_d;
            frame_bad_q <= frame_bad_d;
            rx_data_q   <= rx_data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        samp_d      = samp_q;
        frame_ok_d  = 1'b0;
        frame_bad_d = 1'b0;

        if (state_q != IDLE) begin
            cycle_cnt_d = at_last ? '0 : cycle_cnt_q + 1'b1;
            if (cycle_cnt_q == CNT_S0) samp_d[0] = rx_s;
            if (cycle_cnt_q == CNT_S1) samp_d[1] = rx_s;
        end

        case (state_q)
            IDLE: begin
                cycle_cnt_d = '0;
                bit_cnt_d   = '0;
                if (prev_q && !rx_s) state_d = START;
            end
            START: begin
                if (at_dec && maj) begin
                    state_d = IDLE;
                end else if (at_last) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (at_dec) shift_d[bit_cnt_q] = maj;
                if (at_last) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a following start edge is not missed.
                if (at_dec) begin
                    state_d     = IDLE;
                    frame_ok_d  = maj;
                    frame_bad_d = !maj;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register: a same-cycle accept frees the slot for the new byte.
    always_comb begin
        rx_data_d   = rx_data_q;
        valid_d     = valid_q;
        frame_err_d = frame_bad_q;
        overrun_d   = 1'b0;

        if (valid_q && rx_data_ready) valid_d = 1'b0;

        if (frame_ok_q) begin
            if (!valid_q || rx_data_ready) begin
                rx_data_d = shift_q;
                valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        rx_data       = rx_data_q;
        rx_data_valid = valid_q;
        frame_err     = frame_err_q;
        overrun_err   = overrun_q;
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at default 234 clocks/bit; a monitor
// logs accepted bytes and error-pulse cycles, the main sequence checks them.
module tb_uart_rx_deserializer;

    localparam int CYCLE = 27000000 / 115200;

    logic       clk;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       frame_err;
    logic       overrun_err;

    uart_rx_deserializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx      (uart_rx),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] got_q[$];
    int         ferr_cycles  = 0;
    int         ovr_cycles   = 0;
    int         valid_cycles = 0;

    // Sample just after the falling edge: outputs settled, inputs already set
    // for the coming rising edge.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (rx_data_valid && rx_data_ready) got_q.push_back(rx_data);
            if (frame_err)     ferr_cycles++;
            if (overrun_err)   ovr_cycles++;
            if (rx_data_valid) valid_cycles++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        drive_bit(1'b0, CYCLE);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CYCLE);
        drive_bit(stop_v, CYCLE);
        uart_rx = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  {24'h0, rx_data}, 32'h0);
        check({tag, "_valid"}, {31'h0, rx_data_valid}, 32'h0);
        check({tag, "_ferr"},  {31'h0, frame_err}, 32'h0);
        check({tag, "_ovr"},   {31'h0, overrun_err}, 32'h0);
    endtask

    initial begin
        int         base_n, base_f, base_o, base_v;
        logic [7:0] seq[4];
        seq[0] = 8'h30; seq[1] = 8'h31; seq[2] = 8'h0D; seq[3] = 8'h0A;

        rst_n         = 1'b0;
        uart_rx       = 1'b1;
        rx_data_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single byte
        base_n = got_q.size(); base_f = ferr_cycles; base_o = ovr_cycles;
        send_byte(8'h30, 1'b1);
        repeat (20) @(negedge clk);
        check("t1_count", got_q.size() - base_n, 1);
        check("t1_data",  {24'h0, got_q[base_n]}, 32'h30);
        check("t1_ferr",  ferr_cycles - base_f, 0);
        check("t1_ovr",   ovr_cycles - base_o, 0);

        // Back-to-back frames
        base_n = got_q.size(); base_f = ferr_cycles; base_o = ovr_cycles;
        for (int i = 0; i < 4; i++) send_byte(seq[i], 1'b1);
        repeat (20) @(negedge clk);
        check("t2_count", got_q.size() - base_n, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_data%0d", i), {24'h0, got_q[base_n + i]}, {24'h0, seq[i]});
        check("t2_ferr", ferr_cycles - base_f, 0);
        check("t2_ovr",  ovr_cycles - base_o, 0);

        // Short glitch is rejected, next frame still received
        base_n = got_q.size(); base_f = ferr_cycles; base_o = ovr_cycles; base_v = valid_cycles;
        drive_bit(1'b0, 50);
        drive_bit(1'b1, 3 * CYCLE);
        check("t3_glitch_valid", valid_cycles - base_v, 0);
        check("t3_glitch_ferr",  ferr_cycles - base_f, 0);
        check("t3_glitch_ovr",   ovr_cycles - base_o, 0);
        send_byte(8'h31, 1'b1);
        repeat (20) @(negedge clk);
        check("t3_count", got_q.size() - base_n, 1);
        check("t3_data",  {24'h0, got_q[base_n]}, 32'h31);

        // Framing error
        base_n = got_q.size(); base_f = ferr_cycles; base_o = ovr_cycles; base_v = valid_cycles;
        send_byte(8'h31, 1'b0);
        repeat (20) @(negedge clk);
        check("t4_ferr_cycles", ferr_cycles - base_f, 1);
        check("t4_valid",       valid_cycles - base_v, 0);
        check("t4_ovr",         ovr_cycles - base_o, 0);

        // Overrun with consumer stalled
        rx_data_ready = 1'b0;
        base_n = got_q.size(); base_o = ovr_cycles;
        send_byte(8'h0D, 1'b1);
        send_byte(8'h0A, 1'b1);
        repeat (20) @(negedge clk);
        check("t5_valid_held", {31'h0, rx_data_valid}, 32'h1);
        check("t5_data_held",  {24'h0, rx_data}, 32'h0D);
        check("t5_ovr_cycles", ovr_cycles - base_o, 1);
        rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
        check("t5_valid_cleared", {31'h0, rx_data_valid}, 32'h0);
        check("t5_data_kept",     {24'h0, rx_data}, 32'h0D);
        repeat (2) @(negedge clk);
        check("t5_accepted", got_q.size() - base_n, 1);

        // Reset during bit 4 of 0x5A (bit 4 is 1, so the line is high at reset)
        rx_data_ready = 1'b1;
        base_n = got_q.size();
        drive_bit(1'b0, CYCLE);
        for (int i = 0; i < 4; i++) drive_bit(((8'h5A >> i) & 8'h1) != 0, CYCLE);
        drive_bit(1'b1, CYCLE / 2);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive_bit(1'b1, 12 * CYCLE);
        send_byte(8'h0A, 1'b1);
        repeat (20) @(negedge clk);
        check("t6_count", got_q.size() - base_n, 1);
        check("t6_data",  {24'h0, got_q[base_n]}, 32'h0A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
